// File: rtl/cu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : cu_multicycle
// Brief    : Multi-cycle RV32I control FSM (R/I/LUI/LOAD/STORE/BEQ/BNE) with a
//            shared instruction/data memory req/ready handshake and timeout.
// Revision : 1.0 - initial release
// ============================================================================

module cu_multicycle #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zf,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                rs2_imm_s,
    output logic [1:0]          w_data_s,
    output logic                Reg_Write,
    output logic                IR_Write,
    output logic                PC_Write,
    output logic                pc_src,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_s,
    output logic                illegal_instr,
    output logic                mem_fault
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EX_R     = 4'd3,
        S_EX_I     = 4'd4,
        S_EX_LUI   = 4'd5,
        S_WB       = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [3:0] c_alu_add    = 4'd0;
    localparam logic [3:0] c_alu_sub    = 4'd1;
    localparam logic [3:0] c_alu_sll    = 4'd2;
    localparam logic [3:0] c_alu_slt    = 4'd3;
    localparam logic [3:0] c_alu_sltu   = 4'd4;
    localparam logic [3:0] c_alu_xor    = 4'd5;
    localparam logic [3:0] c_alu_srl    = 4'd6;
    localparam logic [3:0] c_alu_sra    = 4'd7;
    localparam logic [3:0] c_alu_or     = 4'd8;
    localparam logic [3:0] c_alu_and    = 4'd9;
    localparam logic [3:0] c_alu_pass_b = 4'd10;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       r_illegal;
    logic       r_fault;
    logic [3:0] r_alu_op;
    logic       r_rs2_imm;

    logic [3:0] w_r_op;
    logic [3:0] w_i_op;
    logic [3:0] w_alu_op;
    logic       w_wait;
    logic       w_capture;
    logic       w_set_illegal;
    logic       w_set_fault;

    assign w_cnt_inc = r_cnt + 8'd1;

    // funct7[5] only distinguishes SUB/SRA; immediates never turn ADDI into SUB.
    always_comb begin
        w_r_op = c_alu_add;
        case (funct3)
            3'b000: w_r_op = funct7[5] ? c_alu_sub : c_alu_add;
            3'b001: w_r_op = c_alu_sll;
            3'b010: w_r_op = c_alu_slt;
            3'b011: w_r_op = c_alu_sltu;
            3'b100: w_r_op = c_alu_xor;
            3'b101: w_r_op = funct7[5] ? c_alu_sra : c_alu_srl;
            3'b110: w_r_op = c_alu_or;
            3'b111: w_r_op = c_alu_and;
        endcase
        w_i_op = (funct3 == 3'b000) ? c_alu_add : w_r_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
            r_alu_op  <= 4'd0;
            r_rs2_imm <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (w_wait) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (w_capture) begin
                r_alu_op  <= w_alu_op;
                r_rs2_imm <= rs2_imm_s;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_alu_op      = c_alu_add;
        rs2_imm_s     = 1'b0;
        w_data_s      = 2'd0;
        Reg_Write     = 1'b0;
        IR_Write      = 1'b0;
        PC_Write      = 1'b0;
        pc_src        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_s        = 1'b0;
        w_wait        = 1'b0;
        w_capture     = 1'b0;
        w_set_illegal = 1'b0;
        w_set_fault   = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                w_wait  = 1'b1;
                if (mem_ready) begin
                    IR_Write     = 1'b1;
                    PC_Write     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_set_illegal = 1'b1;
                w_state_next  = S_TRAP;
                case (opcode)
                    c_op_r: begin
                        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                            w_set_illegal = 1'b0;
                            w_state_next  = S_EX_R;
                        end
                    end
                    c_op_i: begin
                        w_set_illegal = 1'b0;
                        w_state_next  = S_EX_I;
                    end
                    c_op_lui: begin
                        w_set_illegal = 1'b0;
                        w_state_next  = S_EX_LUI;
                    end
                    c_op_load, c_op_store: begin
                        w_set_illegal = 1'b0;
                        w_state_next  = S_MEM_ADDR;
                    end
                    c_op_branch: begin
                        if (funct3 == 3'b000 || funct3 == 3'b001) begin
                            w_set_illegal = 1'b0;
                            w_state_next  = S_BRANCH;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX_R: begin
                w_alu_op     = w_r_op;
                w_capture    = 1'b1;
                w_state_next = S_WB;
            end
            S_EX_I: begin
                w_alu_op     = w_i_op;
                rs2_imm_s    = 1'b1;
                w_capture    = 1'b1;
                w_state_next = S_WB;
            end
            S_EX_LUI: begin
                w_alu_op     = c_alu_pass_b;
                rs2_imm_s    = 1'b1;
                w_capture    = 1'b1;
                w_state_next = S_WB;
            end
            S_WB: begin
                w_alu_op     = r_alu_op;
                rs2_imm_s    = r_rs2_imm;
                Reg_Write    = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_op     = c_alu_add;
                rs2_imm_s    = 1'b1;
                w_capture    = 1'b1;
                w_state_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_alu_op  = r_alu_op;
                rs2_imm_s = r_rs2_imm;
                mem_req   = 1'b1;
                addr_s    = 1'b1;
                w_wait    = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                Reg_Write    = 1'b1;
                w_data_s     = 2'd1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_alu_op  = r_alu_op;
                rs2_imm_s = r_rs2_imm;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                addr_s    = 1'b1;
                w_wait    = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_alu_op = c_alu_sub;
                if (funct3[0] ? ~zf : zf) begin
                    PC_Write = 1'b1;
                    pc_src   = 1'b1;
                end
                w_state_next = S_FETCH;
            end
            S_TRAP: w_state_next = S_TRAP;
            default: w_state_next = S_IDLE;
        endcase

        // A ready arriving on the limit cycle completes normally.
        if (w_wait && !mem_ready && (w_cnt_inc == c_timeout)) begin
            w_state_next = S_TRAP;
            w_set_fault  = 1'b1;
        end
    end

    always_comb begin
        ALU_OP      = '0;
        ALU_OP[3:0] = w_alu_op;
    end

    assign illegal_instr = r_illegal;
    assign mem_fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_cu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_multicycle
// Brief    : Scoreboard bench for cu_multicycle: driver queues expected outputs
//            per cycle, monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cu_multicycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zf = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] ALU_OP;
    logic       rs2_imm_s;
    logic [1:0] w_data_s;
    logic       Reg_Write, IR_Write, PC_Write, pc_src;
    logic       mem_req, mem_we, addr_s, illegal_instr, mem_fault;

    cu_multicycle #(.ALU_OP_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zf(zf), .mem_ready(mem_ready), .ALU_OP(ALU_OP), .rs2_imm_s(rs2_imm_s),
        .w_data_s(w_data_s), .Reg_Write(Reg_Write), .IR_Write(IR_Write),
        .PC_Write(PC_Write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
        .addr_s(addr_s), .illegal_instr(illegal_instr), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Packed view: {ALU_OP, rs2_imm_s, w_data_s, Reg_Write, IR_Write, PC_Write,
    //               pc_src, mem_req, mem_we, addr_s, illegal_instr, mem_fault}
    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_NOALU = 16'h07FF;

    localparam logic [15:0] E_ZERO    = 16'h0000;
    localparam logic [15:0] E_FWAIT   = 16'h0010;
    localparam logic [15:0] E_FRDY    = 16'h00D0;
    localparam logic [15:0] E_MADDR   = 16'h0800;
    localparam logic [15:0] E_MRD     = 16'h0814;
    localparam logic [15:0] E_WBMEM   = 16'h0300;
    localparam logic [15:0] E_MWR     = 16'h001C;
    localparam logic [15:0] E_ILLEGAL = 16'h0002;
    localparam logic [15:0] E_FAULT   = 16'h0001;

    typedef struct {
        string       name;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void push(input string name, input logic [15:0] e, input logic [15:0] m);
        exp_t t;
        t.name = name;
        t.exp  = e;
        t.mask = m;
        sb.push_back(t);
    endfunction

    task automatic cyc(input string name, input logic rdy, input logic z,
                       input logic [15:0] e, input logic [15:0] m);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zf        = z;
        push(name, e, m);
    endtask

    task automatic rst_seq();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_ready = 1'b0;
        zf        = 1'b0;
        push("reset", E_ZERO, M_ALL);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push("idle", E_ZERO, M_ALL);
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // ALU-class instruction: fetch, decode, execute, writeback, back to fetch.
    task automatic alu_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [15:0] e_ex);
        set_ir(op, f3, f7);
        rst_seq();
        cyc({name, "_fetch"}, 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc({name, "_decode"}, 1'b1, 1'b0, E_ZERO, M_NOALU);
        cyc({name, "_ex"}, 1'b0, 1'b0, e_ex, M_ALL);
        cyc({name, "_wb"}, 1'b0, 1'b0, e_ex | 16'h0100, M_ALL);
        cyc({name, "_refetch"}, 1'b0, 1'b0, E_FWAIT, M_NOALU);
    endtask

    task automatic branch_instr(input string name, input logic [2:0] f3, input logic z,
                                input logic [15:0] e_br);
        set_ir(7'b1100011, f3, 7'd0);
        rst_seq();
        cyc({name, "_fetch"}, 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc({name, "_decode"}, 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc({name, "_branch"}, 1'b0, z, e_br, M_ALL);
        cyc({name, "_refetch"}, 1'b0, 1'b0, E_FWAIT, M_NOALU);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {ALU_OP, rs2_imm_s, w_data_s, Reg_Write, IR_Write, PC_Write,
                       pc_src, mem_req, mem_we, addr_s, illegal_instr, mem_fault};
                n_tests++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (mask %h)", e.name, act, e.exp, e.mask);
                end
            end
        end
    end

    initial begin : stimulus
        alu_instr("add",  7'b0110011, 3'b000, 7'b0000000, 16'h0000);
        alu_instr("sub",  7'b0110011, 3'b000, 7'b0100000, 16'h1000);
        alu_instr("sra",  7'b0110011, 3'b101, 7'b0100000, 16'h7000);
        alu_instr("and",  7'b0110011, 3'b111, 7'b0000000, 16'h9000);
        alu_instr("addi", 7'b0010011, 3'b000, 7'b0100000, 16'h0800);
        alu_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 16'h7800);
        alu_instr("sltiu", 7'b0010011, 3'b011, 7'b0000000, 16'h4800);
        alu_instr("lui",  7'b0110111, 3'b000, 7'b0000000, 16'hA800);

        // Load with three wait cycles in MEM_RD
        set_ir(7'b0000011, 3'b010, 7'd0);
        rst_seq();
        cyc("ld_fetch", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("ld_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("ld_addr", 1'b0, 1'b0, E_MADDR, M_ALL);
        for (int i = 0; i < 3; i++) begin
            cyc("ld_rd_wait", 1'b0, 1'b0, E_MRD, M_ALL);
        end
        cyc("ld_rd_done", 1'b1, 1'b0, E_MRD, M_ALL);
        cyc("ld_wb_mem", 1'b0, 1'b0, E_WBMEM, M_NOALU);
        cyc("ld_refetch", 1'b0, 1'b0, E_FWAIT, M_NOALU);

        // Store completing normally, then a store aborted by reset mid-write
        set_ir(7'b0100011, 3'b010, 7'd0);
        rst_seq();
        cyc("st_fetch", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("st_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("st_addr", 1'b0, 1'b0, E_MADDR, M_ALL);
        cyc("st_wr_wait", 1'b0, 1'b0, E_MWR, M_NOALU);
        cyc("st_wr_done", 1'b1, 1'b0, E_MWR, M_NOALU);
        cyc("st_fetch2", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("st_decode2", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("st_addr2", 1'b0, 1'b0, E_MADDR, M_ALL);
        cyc("st_wr_wait2", 1'b0, 1'b0, E_MWR, M_NOALU);
        rst_seq();
        cyc("st_restart_fetch", 1'b0, 1'b0, E_FWAIT, M_NOALU);

        branch_instr("beq_z1", 3'b000, 1'b1, 16'h1060);
        branch_instr("beq_z0", 3'b000, 1'b0, 16'h1000);
        branch_instr("bne_z1", 3'b001, 1'b1, 16'h1000);
        branch_instr("bne_z0", 3'b001, 1'b0, 16'h1060);

        // Fetch timeout: 15 cycles without ready
        set_ir(7'b0110011, 3'b000, 7'd0);
        rst_seq();
        for (int i = 0; i < 15; i++) begin
            cyc("to_fetch_wait", 1'b0, 1'b0, E_FWAIT, M_NOALU);
        end
        cyc("to_trap", 1'b0, 1'b0, E_FAULT, M_NOALU);
        cyc("to_trap_sticky", 1'b1, 1'b0, E_FAULT, M_NOALU);

        // Ready on the limit cycle wins
        rst_seq();
        for (int i = 0; i < 14; i++) begin
            cyc("lim_fetch_wait", 1'b0, 1'b0, E_FWAIT, M_NOALU);
        end
        cyc("lim_fetch_rdy", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("lim_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("lim_ex_r", 1'b0, 1'b0, 16'h0000, M_ALL);

        // Unsupported encodings
        set_ir(7'b1110011, 3'b000, 7'd0);
        rst_seq();
        cyc("sys_fetch", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("sys_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("sys_trap", 1'b1, 1'b0, E_ILLEGAL, M_NOALU);
        cyc("sys_trap_sticky", 1'b1, 1'b0, E_ILLEGAL, M_NOALU);

        set_ir(7'b0110011, 3'b000, 7'b0000001);
        rst_seq();
        cyc("badf7_fetch", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("badf7_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("badf7_trap", 1'b0, 1'b0, E_ILLEGAL, M_NOALU);

        set_ir(7'b1100011, 3'b100, 7'd0);
        rst_seq();
        cyc("blt_fetch", 1'b1, 1'b0, E_FRDY, M_NOALU);
        cyc("blt_decode", 1'b0, 1'b0, E_ZERO, M_NOALU);
        cyc("blt_trap", 1'b0, 1'b0, E_ILLEGAL, M_NOALU);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
